snow64_long_div_u16_by_u8_arbiter: RTL and testbench
====================================================

Name: snow64_long_div_u16_by_u8_arbiter

Overview:
- Shares one Snow64 u16-by-u8 radix-8 long divider between NUM_REQ requesters.
- Uses round-robin arbitration. Sequences exactly one divide at a time: capture, start pulse, completion wait, response return.
- Each requester sees a valid/ready command channel and a valid/ready response channel.
- Sits between the divider instance and the integer/vector units that need division.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 15, max cycles from div_start to div_valid before error is flagged.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_a  in  NUM_REQ*16  dividends; requester k at bits [16k+15:16k].
- req_b  in  NUM_REQ*8  divisors; requester k at bits [8k+7:8k].
- req_ready  out  NUM_REQ  one-hot command accept, high only in the accept cycle.
- resp_valid  out  NUM_REQ  one-hot response valid.
- resp_data  out  16  quotient for the requester flagged in resp_valid.
- resp_ready  in  NUM_REQ  per-requester response accept.
- busy  out  1  high whenever state is not IDLE.
- timeout_err  out  1  sticky; set on divider timeout; cleared only by reset.
- div_start  out  1  start pulse to divider.
- div_a  out  16  dividend to divider.
- div_b  out  8  divisor to divider.
- div_data  in  16  divider quotient, low 16 bits of the divider output.
- div_valid  in  1  divider result valid.
- div_can_accept_cmd  in  1  divider idle.

Behaviour:
- Reset (async assert, sync release):
  - req_ready=0, resp_valid=0, resp_data=0, busy=0, timeout_err=0.
  - div_start=0, div_a=0, div_b=0.
  - rr_ptr=0, state=IDLE, timer=0.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid is high and div_can_accept_cmd=1, grant the first requester at or after rr_ptr in ascending index with wrap.
  - In that cycle, drive req_ready[g]=1 and register req_a/req_b of g into div_a/div_b and grant index g.
  - Move to ISSUE.
  - If div_can_accept_cmd=0, grant nothing and stay in IDLE.
- ISSUE:
  - div_start=1 for exactly one cycle, with div_a/div_b stable.
  - timer is cleared. Move to WAIT.
- WAIT:
  - div_valid is ignored in the first WAIT cycle, because the divider is still dropping its stale valid.
  - From the second WAIT cycle, div_valid=1 captures div_data into resp_data and moves to RESPOND.
  - Nominal divider latency: start edge plus 6 working cycles. The full command-to-response path is 9 cycles minimum.
  - timer increments each WAIT cycle. If timer reaches TIMEOUT_CYCLES with no valid:
    - set timeout_err;
    - force resp_data=16'hFFFF;
    - go to RESPOND, so the requester is never starved.
- RESPOND:
  - resp_valid[g]=1, held with resp_data stable until resp_ready[g]=1.
  - On handshake, drop resp_valid, set rr_ptr=(g+1) mod NUM_REQ, and return to IDLE.
  - The next grant may happen in the cycle after the handshake, not the same cycle.
- Divisor zero passes through to the divider, which returns quotient 0. The arbiter does not special-case it.
- Only one command is outstanding, so responses are always in grant order and at most one resp_valid bit is set.
- A requester dropping req_valid before its grant loses nothing; requests are sampled only in IDLE.
- req_a/req_b values arriving after the grant do not affect the in-flight divide.
- Reset mid-operation:
  - All outputs return to reset values immediately (async).
  - The in-flight result is discarded.
  - After release, the arbiter stays in IDLE until div_can_accept_cmd=1, which protects against a divider still finishing.
- Simultaneous requests from all requesters are served strictly round-robin; no requester waits more than NUM_REQ-1 other transactions.

Test Plan:
- Single request, requester 0, a=16'h03E8, b=8'h07 -> req_ready[0] one cycle; div_start one pulse; resp_valid[0] with resp_data=16'h008E about 9 cycles after accept.
- Requester 2, a=16'hFFFF, b=8'h01 -> resp_data=16'hFFFF. Requester 1, a=16'h1234, b=8'h00 -> resp_data=16'h0000. timeout_err stays 0 for both.
- All 4 req_valid high continuously, with a=k*100, b=3 for requester k -> grants in order 0,1,2,3,0; quotients 0, 33, 66, 100. Only one resp_valid bit set at any time.
- Hold resp_ready[1]=0 for 20 cycles during RESPOND -> resp_valid[1] and resp_data stay stable; no new req_ready; busy=1 throughout. Grant follows the handshake.
- Divider model never raises div_valid -> after TIMEOUT_CYCLES, timeout_err=1 and resp_data=16'hFFFF to the granted requester. The next transaction then proceeds normally.
- Assert rst_n=0 during WAIT -> all outputs 0 in the same cycle. After release, with div_can_accept_cmd held 0 for 3 cycles, no grant occurs; the grant resumes when it rises.

Source files
------------

// File: rtl/snow64_long_div_u16_by_u8_arbiter_if.sv
// Requester-side command/response channels of the shared u16/u8 divider.
// The arbiter takes the slave side; the requesters (or a bench) take the master side.
interface snow64_long_div_u16_by_u8_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ*16-1:0] req_a;
    logic [NUM_REQ*8-1:0]  req_b;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic [15:0]           resp_data;
    logic [NUM_REQ-1:0]    resp_ready;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/snow64_long_div_u16_by_u8_arbiter.sv
// Round-robin front end sharing one u16-by-u8 long divider among NUM_REQ
// requesters. One divide is in flight at a time: capture, start pulse,
// completion wait (with timeout), then a held response until accepted.
module snow64_long_div_u16_by_u8_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    snow64_long_div_u16_by_u8_arbiter_if.slave bus,
    output logic        busy,
    output logic        timeout_err,
    output logic        div_start,
    output logic [15:0] div_a,
    output logic [7:0]  div_b,
    input  logic [15:0] div_data,
    input  logic        div_valid,
    input  logic        div_can_accept_cmd
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant;
    logic [TMR_W-1:0]   timer;

    logic [NUM_REQ-1:0][15:0] req_a_v;
    logic [NUM_REQ-1:0][7:0]  req_b_v;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] grant_oh;

    assign req_a_v  = bus.req_a;
    assign req_b_v  = bus.req_b;
    assign pick_oh  = NUM_REQ'(1) << pick_idx;
    assign grant_oh = NUM_REQ'(1) << grant;

    // First valid requester at or after rr_ptr; scanning offsets downward
    // lets the smallest offset win.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Sequencer; every output is registered and follows the state transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            grant          <= '0;
            timer          <= '0;
            busy           <= 1'b0;
            timeout_err    <= 1'b0;
            div_start      <= 1'b0;
            div_a          <= '0;
            div_b          <= '0;
            bus.req_ready  <= '0;
            bus.resp_valid <= '0;
            bus.resp_data  <= '0;
        end else begin
            bus.req_ready <= '0;
            div_start     <= 1'b0;
            case (state)
                IDLE: begin
                    // Divider must report idle, which also covers a divider
                    // still finishing work from before a reset.
                    if (pick_vld && div_can_accept_cmd) begin
                        grant         <= pick_idx;
                        div_a         <= req_a_v[pick_idx];
                        div_b         <= req_b_v[pick_idx];
                        bus.req_ready <= pick_oh;
                        div_start     <= 1'b1;
                        busy          <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // timer==0 marks the first WAIT cycle, where div_valid is
                    // still the stale level from the previous divide.
                    if (timer != '0 && div_valid) begin
                        bus.resp_data  <= div_data;
                        bus.resp_valid <= grant_oh;
                        state          <= RESPOND;
                    end else if (timer >= TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err    <= 1'b1;
                        bus.resp_data  <= 16'hFFFF;
                        bus.resp_valid <= grant_oh;
                        state          <= RESPOND;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESPOND: begin
                    if (bus.resp_ready[grant]) begin
                        bus.resp_valid <= '0;
                        rr_ptr         <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                        busy           <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snow64_long_div_u16_by_u8_arbiter.sv
// Directed + randomized bench for the shared divider arbiter, with a
// behavioural divider model and a round-robin/quotient reference model.
module tb_snow64_long_div_u16_by_u8_arbiter;
    localparam int N  = 4;
    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy, timeout_err, div_start;
    logic [15:0] div_a;
    logic [7:0]  div_b;
    logic [15:0] div_data = 16'h0;
    logic        div_valid = 1'b0;
    logic        div_can_accept_cmd;

    always #5 clk = ~clk;

    snow64_long_div_u16_by_u8_arbiter_if #(.NUM_REQ(N)) bus ();

    snow64_long_div_u16_by_u8_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .busy(busy), .timeout_err(timeout_err),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_data(div_data), .div_valid(div_valid),
        .div_can_accept_cmd(div_can_accept_cmd)
    );

    // Divider model: after a start, 6 working cycles then valid held high.
    // Valid keeps its stale level for one cycle after the start edge.
    int          dm_cnt = 0;
    logic [15:0] dm_q = 16'h0;
    bit          dm_hang = 1'b0;
    bit          can_en = 1'b1;

    assign div_can_accept_cmd = (dm_cnt == 0) && can_en;

    always @(posedge clk) begin
        if (div_start) begin
            dm_q   <= (div_b == 8'd0) ? 16'h0 : div_a / {8'h00, div_b};
            dm_cnt <= 6;
        end else if (dm_cnt != 0) begin
            dm_cnt    <= dm_cnt - 1;
            div_valid <= (dm_cnt == 1) && !dm_hang;
            if (dm_cnt == 1) div_data <= dm_q;
        end
    end

    // Reference model state
    int          n_cmp = 0, n_bad = 0;
    int          rr_ptr_m = 0;
    logic [15:0] ta [N];
    logic [7:0]  tbv[N];

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++) begin
            int j = (p + i) % N;
            if (m[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [15:0] qref(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return 16'h0;
        return 16'(int'(a) / int'(b));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {bus.req_ready, bus.resp_valid, busy, timeout_err, div_start, div_b}, 32'h0);
        chk({tag, "_data"}, {bus.resp_data, div_a}, 32'h0);
    endtask

    task automatic set_op(input int k, input logic [15:0] a, input logic [7:0] b);
        ta[k] = a;
        tbv[k] = b;
        bus.req_a[k*16 +: 16] = a;
        bus.req_b[k*8 +: 8]   = b;
    endtask

    // One full transaction with the given request mask; the expected grant
    // comes from the round-robin model, the expected data from qref.
    task automatic run_txn(input logic [N-1:0] mask, input bit oneshot, input int hold,
                           input bit exp_to, input bit chk_lat);
        int g, cyc, starts;
        bit got, extra, stable;
        logic [15:0] exp_q;
        logic [N-1:0] oh;
        g = pick(mask, rr_ptr_m);
        oh = N'(1) << g;
        exp_q = exp_to ? 16'hFFFF : qref(ta[g], tbv[g]);
        bus.req_valid = mask;
        cyc = 0; got = 1'b0; starts = 0; extra = 1'b0;
        while (!got && cyc < 60) begin
            @(negedge clk); cyc++;
            if (div_start) starts++;
            got = (bus.req_ready != '0);
        end
        chk("grant_onehot", 32'(bus.req_ready), 32'(oh));
        chk("div_operands", {div_a, div_b}, {ta[g], tbv[g]});
        got = 1'b0;
        while (!got && cyc < 120) begin
            @(negedge clk); cyc++;
            if (div_start) starts++;
            if (oneshot && bus.req_valid[g]) begin
                // post-grant changes must not reach the in-flight divide
                bus.req_valid[g] = 1'b0;
                bus.req_a[g*16 +: 16] = 16'($urandom);
                bus.req_b[g*8 +: 8]   = 8'($urandom);
            end
            got = (bus.resp_valid != '0);
            if (!got && bus.req_ready != '0) extra = 1'b1;
        end
        chk("no_grant_in_flight", 32'(extra), 32'h0);
        chk("resp_valid_onehot", 32'(bus.resp_valid), 32'(oh));
        chk("resp_data", 32'(bus.resp_data), 32'(exp_q));
        chk("busy_in_respond", 32'(busy), 32'h1);
        chk("start_pulses", starts, 1);
        if (chk_lat) chk("latency", cyc, 9);
        stable = 1'b1;
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = bus.req_valid | ~oh;
            @(negedge clk);
            if (bus.resp_valid !== oh || bus.resp_data !== exp_q || busy !== 1'b1 ||
                bus.req_ready !== '0) stable = 1'b0;
        end
        if (hold > 0) chk("respond_hold_stable", 32'(stable), 32'h1);
        bus.resp_ready = oh;
        @(negedge clk);
        bus.resp_ready = '0;
        chk("released_after_handshake", {busy, bus.resp_valid, bus.req_ready}, 32'h0);
        rr_ptr_m = (g + 1) % N;
    endtask

    initial begin
        int cyc;
        bit bad;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.resp_ready = '0;
        repeat (2) @(negedge clk);
        chk_reset("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request, requester 0
        set_op(0, 16'h03E8, 8'h07);
        run_txn(4'b0001, 1'b1, 0, 1'b0, 1'b1);

        // Max dividend / divide by one, then divide by zero
        set_op(2, 16'hFFFF, 8'h01);
        run_txn(4'b0100, 1'b1, 0, 1'b0, 1'b1);
        set_op(1, 16'h1234, 8'h00);
        run_txn(4'b0010, 1'b1, 0, 1'b0, 1'b1);
        chk("no_timeout_yet", 32'(timeout_err), 32'h0);

        // Move the pointer back to 0 via requester 3
        set_op(3, 16'hBEEF, 8'hFF);
        run_txn(4'b1000, 1'b1, 0, 1'b0, 1'b1);

        // All requesters continuously valid: round robin 0,1,2,3,0
        for (int k = 0; k < N; k++) set_op(k, 16'(k * 100), 8'd3);
        repeat (5) run_txn(4'b1111, 1'b0, 0, 1'b0, 1'b1);
        bus.req_valid = '0;

        // Long response back-pressure on requester 1 with others waiting
        set_op(1, 16'd5000, 8'd9);
        run_txn(4'b0010, 1'b1, 20, 1'b0, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 8; t++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++)
                set_op(k, 16'($urandom), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
            run_txn(m, 1'b1, $urandom_range(0, 3), 1'b0, 1'b1);
        end
        bus.req_valid = '0;

        // Divider never completes: timeout response, then normal service
        dm_hang = 1'b1;
        set_op(2, 16'h7777, 8'h11);
        run_txn(4'b0100, 1'b1, 0, 1'b1, 1'b0);
        chk("timeout_err_set", 32'(timeout_err), 32'h1);
        dm_hang = 1'b0;
        set_op(0, 16'd999, 8'd10);
        run_txn(4'b0001, 1'b1, 0, 1'b0, 1'b1);
        chk("timeout_err_sticky", 32'(timeout_err), 32'h1);

        // Reset while waiting on the divider
        set_op(3, 16'h4321, 8'h05);
        bus.req_valid = 4'b1000;
        cyc = 0;
        while (bus.req_ready == '0 && cyc < 60) begin @(negedge clk); cyc++; end
        repeat (3) @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'h1);
        rst_n = 1'b0;
        can_en = 1'b0;
        #1;
        chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        rr_ptr_m = 0;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (busy !== 1'b0 || bus.req_ready !== '0 || div_start !== 1'b0) bad = 1'b1;
        end
        chk("no_grant_while_divider_busy", 32'(bad), 32'h0);
        can_en = 1'b1;
        run_txn(4'b1000, 1'b1, 0, 1'b0, 1'b0);
        chk("timeout_err_after_reset", 32'(timeout_err), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
